// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM encoding (IDLE / WAIT / RESP)
//   dmem_wr_t    : write half of a latched request (byte enables + data)
//   WORD_W, BE_W : data word width and byte-enable width
//   WAIT_MAX     : largest wait-state count the 4-bit counter can hold
package dmem_pkg;

    localparam int WORD_W   = 32;
    localparam int BE_W     = 4;
    localparam int WAIT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic [BE_W-1:0]   wen;
        logic [WORD_W-1:0] wdata;
    } dmem_wr_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^ADDR_WIDTH x 32-bit byte-enable RAM.
//   Port A (clk, a_en, a_addr, a_wen, a_wdata -> a_rdata): synchronous
//     read/write; a_rdata returns the word as it was before the write and
//     holds its value while a_en is low.
//   Port B (b_addr -> b_rdata): synchronous read-only, sampled every cycle;
//     a same-cycle write on port A is seen one cycle later.
//   reset clears only the output registers, never the storage.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [BE_W-1:0]       a_wen,
    input  logic [WORD_W-1:0]     a_wdata,
    output logic [WORD_W-1:0]     a_rdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [WORD_W-1:0]     b_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // One independent byte-wide memory per lane keeps each lane's write
    // enable local and avoids partial-word writes into a shared array.
    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] a_q;
        logic [7:0] b_q;

        always_ff @(posedge clk) begin
            if (a_en && a_wen[g]) begin
                lane_mem[a_addr] <= a_wdata[8*g +: 8];
            end
        end

        // Reads use the pre-edge contents, so both ports see old data on a
        // colliding write.
        always_ff @(posedge clk) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                if (a_en) begin
                    a_q <= lane_mem[a_addr];
                end
                b_q <= lane_mem[b_addr];
            end
        end

        assign a_rdata[8*g +: 8] = a_q;
        assign b_rdata[8*g +: 8] = b_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory behind a valid/ready request and
// response handshake, with WAIT_CYCLES wait states between accept and access.
//   clk, reset                  : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake (one transaction in flight)
//   req_addr, req_wen, req_wdata: byte address, byte enables (0 = read), data
//   resp_valid/resp_ready       : response handshake
//   resp_rdata                  : word before the access (reads and writes)
//   busy                        : transaction in flight
//   dbg_addr -> dbg_data        : registered read-only display port
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        busy,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    dmem_state_t           state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    dmem_wr_t              wr_q;
    logic                  accept;
    logic                  commit;

    // req_ready is a registered copy of (state == IDLE).
    assign accept = req_valid && req_ready;

    // Reset suppresses the access so a write still waiting is dropped.
    assign commit = (state == WAIT) && (cnt == 4'd0) && !reset;

    // Only the word-select bits of the addresses matter; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0],
                                dbg_addr[31:ADDR_WIDTH+2], dbg_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= WAIT_LD;
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Request fields are captured once, at accept; later changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            idx_q      <= req_addr[ADDR_WIDTH+1:2];
            wr_q.wen   <= req_wen;
            wr_q.wdata <= req_wdata;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .a_en    (commit),
        .a_addr  (idx_q),
        .a_wen   (wr_q.wen),
        .a_wdata (wr_q.wdata),
        .a_rdata (resp_rdata),
        .b_addr  (dbg_addr[ADDR_WIDTH+1:2]),
        .b_rdata (dbg_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Three instances with
// different wait-state counts share the input bus; 'sel' chooses which one
// sees req_valid and whose outputs are observed through the m_* signals.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b1;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] dbg_addr = '0;
    logic [3:0]  req_wen = '0;
    logic [1:0]  sel = 2'd0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [2:0]  rq_rdy, rs_vld, bsy;
    logic [31:0] rs_d0, rs_d1, rs_d2, dbg_d0, dbg_d1, dbg_d2;
    logic        m_req_ready, m_resp_valid, m_busy;
    logic [31:0] m_resp_rdata, m_dbg_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u_dut0: W=1, u_dut1: W=3, u_dut2: W=0
    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2'd0),
        .req_ready(rq_rdy[0]), .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .resp_valid(rs_vld[0]), .resp_ready(resp_ready),
        .resp_rdata(rs_d0), .busy(bsy[0]), .dbg_addr(dbg_addr), .dbg_data(dbg_d0));
    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2'd1),
        .req_ready(rq_rdy[1]), .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .resp_valid(rs_vld[1]), .resp_ready(resp_ready),
        .resp_rdata(rs_d1), .busy(bsy[1]), .dbg_addr(dbg_addr), .dbg_data(dbg_d1));
    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2'd2),
        .req_ready(rq_rdy[2]), .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .resp_valid(rs_vld[2]), .resp_ready(resp_ready),
        .resp_rdata(rs_d2), .busy(bsy[2]), .dbg_addr(dbg_addr), .dbg_data(dbg_d2));

    always_comb begin
        m_req_ready  = rq_rdy[0];
        m_resp_valid = rs_vld[0];
        m_busy       = bsy[0];
        m_resp_rdata = rs_d0;
        m_dbg_data   = dbg_d0;
        case (sel)
            2'd1: begin
                m_req_ready = rq_rdy[1]; m_resp_valid = rs_vld[1]; m_busy = bsy[1];
                m_resp_rdata = rs_d1; m_dbg_data = dbg_d1;
            end
            2'd2: begin
                m_req_ready = rq_rdy[2]; m_resp_valid = rs_vld[2]; m_busy = bsy[2];
                m_resp_rdata = rs_d2; m_dbg_data = dbg_d2;
            end
            default: ;
        endcase
    end

    // One full transaction with resp_ready high; returns rdata and the
    // accept-to-first-resp_valid latency in cycles.
    task automatic txn(input logic [1:0] d, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int n;
        int t0;
        @(negedge clk);
        sel = d; req_addr = a; req_wen = w; req_wdata = wd; req_valid = 1'b1; resp_ready = 1'b1;
        n = 0;
        while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL txn_accept_timeout: dut=%0d waited %0d cycles", d, n); end
        t0 = cyc;
        @(negedge clk);
        // scramble the bus after accept: the latched request must not change
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wen = 4'hF; req_wdata = 32'hDEAD_BEEF;
        n = 0;
        while (!m_resp_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL txn_resp_timeout: dut=%0d waited %0d cycles", d, n); end
        lat = cyc - t0;
        rd = m_resp_rdata;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; sel = 2'd0; req_valid = 1'b1; req_addr = 32'h14; req_wen = 4'hF;
        req_wdata = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        total += 5;
        if (rq_rdy !== 3'b111) begin bad++; $display("FAIL reset_req_ready: got %b want 111", rq_rdy); end
        if (bsy !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", bsy); end
        if (rs_vld !== 3'b000) begin bad++; $display("FAIL reset_resp_valid: got %b want 000", rs_vld); end
        if ({rs_d0, rs_d1, rs_d2} !== 96'h0) begin
            bad++; $display("FAIL reset_resp_rdata: got %h %h %h want 0", rs_d0, rs_d1, rs_d2);
        end
        if ({dbg_d0, dbg_d1, dbg_d2} !== 96'h0) begin
            bad++; $display("FAIL reset_dbg_data: got %h %h %h want 0", dbg_d0, dbg_d1, dbg_d2);
        end
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bsy[0] !== 1'b0) begin bad++; $display("FAIL reset_with_valid: busy=%b want 0", bsy[0]); end
    endtask

    task automatic test_read_latency;
        logic [31:0] rd;
        int lat;
        txn(2'd0, 32'h14, 4'hF, 32'h1234_5678, rd, lat);
        txn(2'd0, 32'h14, 4'h0, 32'hFFFF_FFFF, rd, lat);
        total += 2;
        if (rd !== 32'h1234_5678) begin bad++; $display("FAIL read_data: got %h want 12345678", rd); end
        if (lat !== 3) begin bad++; $display("FAIL read_latency: got %0d want 3", lat); end
    endtask

    task automatic test_partial_write;
        logic [31:0] rd;
        int lat;
        txn(2'd0, 32'h14, 4'b0101, 32'hAABB_CCDD, rd, lat);
        total += 2;
        if (rd !== 32'h1234_5678) begin bad++; $display("FAIL pwrite_old: got %h want 12345678", rd); end
        if (lat !== 3) begin bad++; $display("FAIL pwrite_latency: got %0d want 3", lat); end
        txn(2'd0, 32'h17, 4'h0, 32'h0, rd, lat);
        total++;
        if (rd !== 32'h12BB_56DD) begin bad++; $display("FAIL pwrite_merge: got %h want 12bb56dd", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        int lat;
        int n;
        int t_acc;
        txn(2'd0, 32'h1C, 4'hF, 32'h0000_0077, rd, lat);
        @(negedge clk);
        sel = 2'd0; req_addr = 32'h1C; req_wen = 4'h0; req_valid = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h14;  // second request, held while the first is pending
        n = 0;
        while (!m_resp_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL bp_resp_timeout: waited %0d cycles", n); end
        for (int i = 0; i < 6; i++) begin
            total += 3;
            if (m_resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold: cycle %0d got %b want 1", i, m_resp_valid); end
            if (m_resp_rdata !== 32'h77) begin bad++; $display("FAIL bp_data_hold: cycle %0d got %h want 00000077", i, m_resp_rdata); end
            if (m_req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready: cycle %0d got %b want 0", i, m_req_ready); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total += 2;
        if (m_req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", m_req_ready); end
        if (m_resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", m_resp_valid); end
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (m_busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept: busy=%b want 1", m_busy); end
        n = 0;
        while (!m_resp_valid && n < 20) begin @(negedge clk); n++; end
        total += 2;
        if (cyc - t_acc !== 3) begin bad++; $display("FAIL bp_second_latency: got %0d want 3", cyc - t_acc); end
        if (m_resp_rdata !== 32'h12BB_56DD) begin bad++; $display("FAIL bp_second_data: got %h want 12bb56dd", m_resp_rdata); end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] rd;
        int lat;
        int n;
        logic seen;
        txn(2'd1, 32'h0C, 4'hF, 32'h0303_0303, rd, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL w3_latency: got %0d want 5", lat); end
        @(negedge clk);
        sel = 2'd1; req_addr = 32'h0C; req_wen = 4'hF; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (m_busy !== 1'b1) begin bad++; $display("FAIL rmw_accept: busy=%b want 1", m_busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total += 2;
        if (m_busy !== 1'b0) begin bad++; $display("FAIL rmw_busy: got %b want 0", m_busy); end
        if (m_resp_valid !== 1'b0) begin bad++; $display("FAIL rmw_valid: got %b want 0", m_resp_valid); end
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (m_resp_valid) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rmw_no_resp: saw resp_valid=%b want 0", seen); end
        txn(2'd1, 32'h0C, 4'h0, 32'h0, rd, lat);
        total++;
        if (rd !== 32'h0303_0303) begin bad++; $display("FAIL rmw_uncommitted: got %h want 03030303", rd); end
        // a write already committed (RESP) survives reset
        @(negedge clk);
        req_addr = 32'h10; req_wen = 4'hF; req_wdata = 32'h4444_4444; req_valid = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!m_resp_valid && n < 20) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; resp_ready = 1'b1;
        total++;
        if (m_resp_valid !== 1'b0) begin bad++; $display("FAIL rresp_valid: got %b want 0", m_resp_valid); end
        txn(2'd1, 32'h10, 4'h0, 32'h0, rd, lat);
        total++;
        if (rd !== 32'h4444_4444) begin bad++; $display("FAIL rresp_committed: got %h want 44444444", rd); end
    endtask

    task automatic test_alias_debug;
        logic [31:0] rd;
        int lat;
        int n;
        dbg_addr = 32'h400;
        txn(2'd0, 32'h0, 4'hF, 32'h1111_1111, rd, lat);
        @(negedge clk);
        sel = 2'd0; req_addr = 32'h8000_0402; req_wen = 4'hF; req_wdata = 32'hCAFE_0001;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!m_resp_valid && n < 20) begin @(negedge clk); n++; end
        total += 2;
        if (m_resp_rdata !== 32'h1111_1111) begin bad++; $display("FAIL alias_old: got %h want 11111111", m_resp_rdata); end
        if (m_dbg_data !== 32'h1111_1111) begin bad++; $display("FAIL dbg_commit_edge: got %h want 11111111", m_dbg_data); end
        @(negedge clk);
        dbg_addr = 32'h403;
        total++;
        if (m_dbg_data !== 32'hCAFE_0001) begin bad++; $display("FAIL dbg_after_commit: got %h want cafe0001", m_dbg_data); end
        @(negedge clk);
        dbg_addr = 32'h14;
        total++;
        if (m_dbg_data !== 32'hCAFE_0001) begin bad++; $display("FAIL dbg_low_bits: got %h want cafe0001", m_dbg_data); end
        @(negedge clk);
        total++;
        if (m_dbg_data !== 32'h12BB_56DD) begin bad++; $display("FAIL dbg_word5: got %h want 12bb56dd", m_dbg_data); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int lat;
        int acc [2];
        int rsp [2];
        logic [31:0] rdat [2];
        int na;
        int nr;
        acc = '{0, 0}; rsp = '{0, 0}; rdat = '{32'h0, 32'h0};
        na = 0; nr = 0;
        txn(2'd2, 32'h4, 4'hF, 32'hB2B2_0001, rd, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL w0_latency: got %0d want 2", lat); end
        @(negedge clk);
        sel = 2'd2; req_addr = 32'h4; req_wen = 4'h0; req_valid = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (na == 2) req_valid = 1'b0;
            if (req_valid && m_req_ready && na < 2) begin acc[na] = cyc; na++; end
            if (m_resp_valid && nr < 2) begin rsp[nr] = cyc; rdat[nr] = m_resp_rdata; nr++; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        total += 5;
        if (na !== 2 || nr !== 2) begin bad++; $display("FAIL b2b_counts: accepts=%0d resps=%0d want 2 2", na, nr); end
        if (acc[1] - acc[0] !== 3) begin bad++; $display("FAIL b2b_accept_gap: got %0d want 3", acc[1] - acc[0]); end
        if (rsp[0] - acc[0] !== 2) begin bad++; $display("FAIL b2b_resp0: got %0d want 2", rsp[0] - acc[0]); end
        if (rsp[1] - acc[0] !== 5) begin bad++; $display("FAIL b2b_resp1: got %0d want 5", rsp[1] - acc[0]); end
        if (rdat[0] !== 32'hB2B2_0001 || rdat[1] !== 32'hB2B2_0001) begin
            bad++; $display("FAIL b2b_data: got %h %h want b2b20001", rdat[0], rdat[1]);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_partial_write();
        test_backpressure();
        test_reset_mid_write();
        test_alias_debug();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
